fsk_symbol_ctrl: RTL and testbench

//  Symbol scheduler for the FSK2 transmitter. Buffers incoming data bits in a small FIFO and

---
 rtl/fsk_symbol_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_fsk_symbol_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fsk_symbol_ctrl.sv
// -----------------------------------------------------------------------------
// fsk_symbol_ctrl
// Symbol scheduler for the FSK2 transmitter. Incoming data bits are buffered
// in a small FIFO. For each bit, the block restarts the matching dds_sine tone
// generator with a one-cycle pulse (space = 0, mark = 1). It then holds the
// output-mux select for SYM_CLKS cycles. An optional idle gap of GAP_CLKS
// cycles can follow each symbol.
//
// State table
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for enable with at least one bit buffered
//   ST_LOAD | one cycle; pops the head bit and arms the first SEND cycle
//   ST_SEND | tone selected for SYM_CLKS cycles; chains to the next bit
//           | directly when there is no gap
//   ST_GAP  | GAP_CLKS idle cycles; tx_active low, tone_sel held
//
// Ports
//   sys_clk, sys_rst_n  clock (rising edge) and async active-low reset
//   enable              run permission, sampled on symbol boundaries
//   bit_valid/bit_data  upstream bit stream; bit_ready is the FIFO accept
//   tone0/1_toggle      restart pulses to the space/mark dds_sine
//   tone_sel            output-mux select, 0 = space, 1 = mark
//   tx_active           high on every SEND cycle
//   sym_done            one-cycle pulse after each completed symbol
//   underrun            one-cycle pulse when a symbol ends enabled but starved
//   fifo_level          current FIFO occupancy
// -----------------------------------------------------------------------------
module fsk_symbol_ctrl #(
    parameter int unsigned SYM_CLKS = 200,
    parameter int unsigned GAP_CLKS = 0,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     enable,
    input  logic                     bit_valid,
    input  logic                     bit_data,
    output logic                     bit_ready,
    output logic                     tone0_toggle,
    output logic                     tone1_toggle,
    output logic                     tone_sel,
    output logic                     tx_active,
    output logic                     sym_done,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned LW       = AW + 1;
    localparam logic [15:0] SYM_LAST = 16'(SYM_CLKS);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CLKS);
    localparam logic        HAS_GAP  = (GAP_CLKS != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t            state;
    logic [15:0]       sym_cnt;
    logic [15:0]       gap_cnt;

    logic [DEPTH-1:0]  mem;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    logic              push;
    logic              pop;
    logic              have_data;
    logic              sym_end;
    logic              chain;
    logic              head;

    assign bit_ready = (fifo_level != LW'(DEPTH));
    assign push      = bit_valid & bit_ready;
    // Decisions use the registered level, so a push in the same cycle does not count.
    assign have_data = (fifo_level != '0);
    assign sym_end   = (state == ST_SEND) && (sym_cnt == SYM_LAST);
    // Back-to-back symbol: pop the next bit on the last SEND cycle, with no dead cycle.
    assign chain     = sym_end && !HAS_GAP && enable && have_data;
    assign pop       = (state == ST_LOAD) || chain;
    assign head      = mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= bit_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= ST_IDLE;
            sym_cnt      <= '0;
            gap_cnt      <= '0;
            tone0_toggle <= 1'b0;
            tone1_toggle <= 1'b0;
            tone_sel     <= 1'b0;
            tx_active    <= 1'b0;
            sym_done     <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            tone0_toggle <= 1'b0;
            tone1_toggle <= 1'b0;
            sym_done     <= 1'b0;
            underrun     <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    tx_active <= 1'b0;
                    if (enable && have_data) begin
                        state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    state        <= ST_SEND;
                    sym_cnt      <= 16'd1;
                    tone_sel     <= head;
                    tone1_toggle <= head;
                    tone0_toggle <= ~head;
                    tx_active    <= 1'b1;
                end

                ST_SEND: begin
                    if (!sym_end) begin
                        sym_cnt <= sym_cnt + 16'd1;
                    end else begin
                        sym_done <= 1'b1;
                        if (HAS_GAP) begin
                            state     <= ST_GAP;
                            gap_cnt   <= 16'd1;
                            tx_active <= 1'b0;
                        end else if (chain) begin
                            sym_cnt      <= 16'd1;
                            tone_sel     <= head;
                            tone1_toggle <= head;
                            tone0_toggle <= ~head;
                        end else begin
                            state     <= ST_IDLE;
                            tx_active <= 1'b0;
                            underrun  <= enable;
                        end
                    end
                end

                ST_GAP: begin
                    tx_active <= 1'b0;
                    if (gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end else if (enable && have_data) begin
                        state <= ST_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsk_symbol_ctrl.sv
module tb_fsk_symbol_ctrl;

    logic       sys_clk;
    logic       sys_rst_n;

    logic       enable, bit_valid, bit_data;
    logic       bit_ready, tone0_toggle, tone1_toggle, tone_sel;
    logic       tx_active, sym_done, underrun;
    logic [2:0] fifo_level;

    logic       enable_g, bit_valid_g, bit_data_g;
    logic       bit_ready_g, tone0_toggle_g, tone1_toggle_g, tone_sel_g;
    logic       tx_active_g, sym_done_g, underrun_g;
    logic [2:0] fifo_level_g;

    int total = 0;
    int bad   = 0;

    fsk_symbol_ctrl #(.SYM_CLKS(8), .GAP_CLKS(0), .DEPTH(4)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable),
        .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
        .tone0_toggle(tone0_toggle), .tone1_toggle(tone1_toggle),
        .tone_sel(tone_sel), .tx_active(tx_active), .sym_done(sym_done),
        .underrun(underrun), .fifo_level(fifo_level)
    );

    fsk_symbol_ctrl #(.SYM_CLKS(8), .GAP_CLKS(3), .DEPTH(4)) dut_g (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable_g),
        .bit_valid(bit_valid_g), .bit_data(bit_data_g), .bit_ready(bit_ready_g),
        .tone0_toggle(tone0_toggle_g), .tone1_toggle(tone1_toggle_g),
        .tone_sel(tone_sel_g), .tx_active(tx_active_g), .sym_done(sym_done_g),
        .underrun(underrun_g), .fifo_level(fifo_level_g)
    );

    // {tone0, tone1, sel, tx_active, sym_done, underrun}
    logic [5:0] o, og;
    assign o  = {tone0_toggle, tone1_toggle, tone_sel, tx_active, sym_done, underrun};
    assign og = {tone0_toggle_g, tone1_toggle_g, tone_sel_g, tx_active_g, sym_done_g, underrun_g};

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    logic [3:0] bits2;
    logic [5:0] e;
    int         j;
    logic       sel_exp;

    initial begin
        enable = 0; bit_valid = 0; bit_data = 0;
        enable_g = 0; bit_valid_g = 0; bit_data_g = 0;
        sys_rst_n = 0;
        #23;
        chk("reset_outs", 0, {2'b0, o}, 8'h00);
        chk("reset_level", 0, {5'b0, fifo_level}, 8'd0);
        chk("reset_ready", 0, {7'b0, bit_ready}, 8'd1);
        @(negedge sys_clk);
        sys_rst_n = 1;
        step(); step();

        // 1: single mark bit, underrun at the end
        enable = 1; bit_valid = 1; bit_data = 1;
        for (int c = 0; c <= 12; c++) begin
            if (c == 1) bit_valid = 0;
            e = {1'b0, c == 3, c >= 3, (c >= 3 && c <= 10), c == 11, c == 11};
            chk("t1_outs", c, {2'b0, o}, {2'b0, e});
            step();
        end
        enable = 0;
        step();

        // 2/3: fill the FIFO with enable low, then run four back-to-back symbols
        bits2 = 4'b1101; // bits2[0] first: 1,0,1,1
        bit_valid = 1;
        for (int p = 0; p <= 5; p++) begin
            if (p < 4) bit_data = bits2[p];
            chk("t3_level", p, {5'b0, fifo_level}, (p < 4) ? 8'(p) : 8'd4);
            chk("t3_ready", p, {7'b0, bit_ready}, (p < 4) ? 8'd1 : 8'd0);
            step();
        end
        bit_valid = 0;
        chk("t3_full", 6, {5'b0, fifo_level}, 8'd4);
        enable = 1;
        for (int c = 0; c <= 36; c++) begin
            j = (c >= 2) ? (c - 2) / 8 : 0;
            if (j > 3) j = 3;
            sel_exp = (c < 2) ? 1'b1 : bits2[j];
            e[5] = (c >= 2 && c < 34 && (c - 2) % 8 == 0) ? ~bits2[j] : 1'b0;
            e[4] = (c >= 2 && c < 34 && (c - 2) % 8 == 0) ?  bits2[j] : 1'b0;
            e[3] = sel_exp;
            e[2] = (c >= 2 && c < 34);
            e[1] = (c >= 10 && c <= 34 && (c - 2) % 8 == 0);
            e[0] = (c == 34);
            chk("t2_outs", c, {2'b0, o}, {2'b0, e});
            if (c == 1) chk("t3_ready_load", c, {7'b0, bit_ready}, 8'd0);
            if (c == 2) chk("t3_ready_after_pop", c, {7'b0, bit_ready}, 8'd1);
            step();
        end
        enable = 0;
        step();

        // 4: drop enable mid-symbol, symbol completes, FIFO retained
        bit_valid = 1; bit_data = 0;
        step();
        bit_data = 1;
        step();
        bit_valid = 0;
        chk("t4_level_pre", 0, {5'b0, fifo_level}, 8'd2);
        enable = 1;
        for (int c = 0; c <= 13; c++) begin
            if (c == 4) enable = 0;
            e = {c == 2, 1'b0, c < 2, (c >= 2 && c <= 9), c == 10, 1'b0};
            chk("t4_outs", c, {2'b0, o}, {2'b0, e});
            step();
        end
        chk("t4_level_post", 14, {5'b0, fifo_level}, 8'd1);
        chk("t4_ready_post", 14, {7'b0, bit_ready}, 8'd1);

        // 5: gap instance, bits 1 then 0
        bit_valid_g = 1; bit_data_g = 1;
        step();
        bit_data_g = 0;
        step();
        bit_valid_g = 0;
        chk("t5_level_pre", 0, {5'b0, fifo_level_g}, 8'd2);
        enable_g = 1;
        for (int c = 0; c <= 26; c++) begin
            e = {c == 14, c == 2, (c >= 2 && c < 14),
                 ((c >= 2 && c <= 9) || (c >= 14 && c <= 21)),
                 (c == 10 || c == 22), 1'b0};
            chk("t5_outs", c, {2'b0, og}, {2'b0, e});
            step();
        end
        enable_g = 0;

        // 6: async reset mid-symbol with bits still queued
        bit_valid = 1; bit_data = 1;
        step(); step();
        bit_valid = 0;
        chk("t6_level_pre", 0, {5'b0, fifo_level}, 8'd3);
        enable = 1;
        for (int c = 0; c <= 6; c++) begin
            e = {1'b0, c == 2, c >= 2, c >= 2, 1'b0, 1'b0};
            chk("t6_outs", c, {2'b0, o}, {2'b0, e});
            if (c < 6) step();
        end
        #1;
        sys_rst_n = 0;
        #1;
        chk("t6_rst_outs", 6, {2'b0, o}, 8'h00);
        chk("t6_rst_level", 6, {5'b0, fifo_level}, 8'd0);
        chk("t6_rst_ready", 6, {7'b0, bit_ready}, 8'd1);
        @(negedge sys_clk);
        sys_rst_n = 1;
        for (int c = 0; c < 12; c++) begin
            step();
            chk("t6_post_outs", c, {2'b0, o}, 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
